// File: rtl/rfid_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rfid_onchip_mem_arbiter
//
// Shares one single-port on-chip RAM between two Avalon-style requesters:
// port A (Nios data master) and port B (RFID capture/replay engine).
//
// The grant decision is combinational: the winner's command drives mem_* in
// the same cycle it is accepted. At most one access is granted per cycle.
// Read data returns one cycle after the accepted read and is flagged to the
// issuing port through a registered read tag.
//
// Arbitration:
//   IDLE  : no owner. A single requester wins. If both request, the port
//           that did not win last time wins.
//   OWN_x : x keeps winning while it requests, unless the other port has
//           been waiting and x already holds MAX_HOLD consecutive grants.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   a_*/b_*  req,write,addr,   requester command (held until accepted)
//            wdata,be
//   a_wait/b_wait              waitrequest, low in the accept cycle
//   a_rvalid/b_rvalid, *_rdata read response, one cycle after accept
//   mem_cs,mem_write,mem_addr, RAM command
//   mem_wdata,mem_be
//   mem_clken                  RAM clock enable (low only during reset)
//   mem_readdata               RAM q, valid the cycle after a read
//
// Optional feature (macro MEM_ARB_GRANT_CNT_EN):
//   cnt_clr                    synchronous clear of the grant counters
//   a_grant_cnt/b_grant_cnt    16-bit saturating accepted-access counters
// ---------------------------------------------------------------------------
module rfid_onchip_mem_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                a_req,
    input  logic                a_write,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    input  logic [DATA_W/8-1:0] a_be,
    output logic                a_wait,
    output logic                a_rvalid,
    output logic [DATA_W-1:0]   a_rdata,

    input  logic                b_req,
    input  logic                b_write,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wdata,
    input  logic [DATA_W/8-1:0] b_be,
    output logic                b_wait,
    output logic                b_rvalid,
    output logic [DATA_W-1:0]   b_rdata,

    output logic                mem_cs,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    output logic                mem_clken,
`ifdef MEM_ARB_GRANT_CNT_EN
    input  logic                cnt_clr,
    output logic [15:0]         a_grant_cnt,
    output logic [15:0]         b_grant_cnt,
`endif
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       last_b, last_b_nxt;     // 1: B won the most recent grant
    logic [3:0] hold_cnt, hold_cnt_nxt;
    logic       grant_a, grant_b;
    logic       rd_a_vld_p1, rd_b_vld_p1;

    function automatic logic [3:0] hold_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Grant decision. Forced off while reset is asserted so that no RAM
    // access is issued and waitrequest simply mirrors req.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset) begin
            case (state)
                OWN_A: begin
                    if (a_req && (!b_req || hold_cnt < MAX_HOLD_C))
                        grant_a = 1'b1;
                    else
                        grant_b = b_req;
                end
                OWN_B: begin
                    if (b_req && (!a_req || hold_cnt < MAX_HOLD_C))
                        grant_b = 1'b1;
                    else
                        grant_a = a_req;
                end
                default: begin
                    if (a_req && b_req) begin
                        grant_a = last_b;
                        grant_b = !last_b;
                    end else begin
                        grant_a = a_req;
                        grant_b = b_req;
                    end
                end
            endcase
        end
    end

    // Ownership and hold count follow the winner. The hold count only
    // advances while the other port is actually waiting, so a port that
    // streams alone does not use up its budget before contention starts.
    always_comb begin
        state_nxt    = IDLE;
        hold_cnt_nxt = 4'd0;
        last_b_nxt   = last_b;
        if (grant_a) begin
            state_nxt  = OWN_A;
            last_b_nxt = 1'b0;
            if (state == OWN_A)
                hold_cnt_nxt = b_req ? hold_inc(hold_cnt) : hold_cnt;
            else
                hold_cnt_nxt = 4'd1;
        end else if (grant_b) begin
            state_nxt  = OWN_B;
            last_b_nxt = 1'b1;
            if (state == OWN_B)
                hold_cnt_nxt = a_req ? hold_inc(hold_cnt) : hold_cnt;
            else
                hold_cnt_nxt = 4'd1;
        end
    end

    // Stage p0 -> p1: arbitration state and read tags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_b      <= 1'b1;
            hold_cnt    <= 4'd0;
            rd_a_vld_p1 <= 1'b0;
            rd_b_vld_p1 <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_b      <= last_b_nxt;
            hold_cnt    <= hold_cnt_nxt;
            rd_a_vld_p1 <= grant_a && !a_write;
            rd_b_vld_p1 <= grant_b && !b_write;
        end
    end

    assign a_wait    = a_req && !grant_a;
    assign b_wait    = b_req && !grant_b;

    assign mem_cs    = grant_a || grant_b;
    assign mem_write = grant_a ? a_write : (grant_b && b_write);
    assign mem_addr  = grant_b ? b_addr  : a_addr;
    assign mem_wdata = grant_b ? b_wdata : a_wdata;
    assign mem_be    = grant_b ? b_be    : a_be;
    assign mem_clken = !reset;

    assign a_rvalid  = rd_a_vld_p1;
    assign b_rvalid  = rd_b_vld_p1;
    assign a_rdata   = mem_readdata;
    assign b_rdata   = mem_readdata;

`ifdef MEM_ARB_GRANT_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_grant_cnt <= 16'd0;
            b_grant_cnt <= 16'd0;
        end else if (cnt_clr) begin
            a_grant_cnt <= 16'd0;
            b_grant_cnt <= 16'd0;
        end else begin
            if (grant_a) a_grant_cnt <= sat_inc16(a_grant_cnt);
            if (grant_b) b_grant_cnt <= sat_inc16(b_grant_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_rfid_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rfid_onchip_mem_arbiter
//
// Directed bench for rfid_onchip_mem_arbiter. A small behavioural RAM with
// byte enables and one-cycle read latency sits on the mem_* port; a few
// locations are loaded while reset is held. Inputs change 1 time unit after
// the rising edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_rfid_onchip_mem_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              a_req, a_write, b_req, b_write;
    logic [ADDR_W-1:0] a_addr, b_addr, mem_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_readdata;
    logic [BE_W-1:0]   a_be, b_be, mem_be;
    logic              a_wait, b_wait, a_rvalid, b_rvalid;
    logic              mem_cs, mem_write, mem_clken;
`ifdef MEM_ARB_GRANT_CNT_EN
    logic              cnt_clr;
    logic [15:0]       a_grant_cnt, b_grant_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    int a_cnt, b_gcyc, a_lastcyc;
    bit b_chk, ga, gb;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    rfid_onchip_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(4)
    ) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
        .a_wait(a_wait), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
        .b_wait(b_wait), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_cs(mem_cs), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_clken(mem_clken),
`ifdef MEM_ARB_GRANT_CNT_EN
        .cnt_clr(cnt_clr), .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt),
`endif
        .mem_readdata(mem_readdata)
    );

    // Behavioural single-port RAM, contents loaded during reset
    always @(posedge clk) begin
        if (reset) begin
            ram[13'h0010] <= 32'hDEADBEEF;
            ram[13'h0020] <= 32'h11111111;
            ram[13'h0021] <= 32'h22222222;
            ram[13'h0022] <= 32'h33333333;
            ram[13'h0023] <= 32'h44444444;
            ram[13'h0040] <= 32'h55555555;
            ram[13'h1FFF] <= 32'h00000000;
        end else if (mem_cs) begin
            if (mem_write) begin
                for (int i = 0; i < BE_W; i++)
                    if (mem_be[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end else begin
                mem_readdata <= ram[mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One access from one port, accepted in the first cycle it is presented
    task automatic acc(input bit port_b, input bit wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input logic [BE_W-1:0] be,
                       input string tag);
        if (port_b) begin
            b_req = 1'b1; b_write = wr; b_addr = addr; b_wdata = wdata; b_be = be;
        end else begin
            a_req = 1'b1; a_write = wr; a_addr = addr; a_wdata = wdata; a_be = be;
        end
        @(negedge clk);
        check({tag, "_wait"}, port_b ? b_wait : a_wait, 0);
        check({tag, "_cs"}, mem_cs, 1);
        check({tag, "_addr"}, mem_addr, addr);
        check({tag, "_wr"}, mem_write, wr);
        if (wr) begin
            check({tag, "_wdata"}, mem_wdata, wdata);
            check({tag, "_be"}, mem_be, be);
        end
        next_cycle();
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        a_req = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0; a_be = '1;
        b_req = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0; b_be = '1;
`ifdef MEM_ARB_GRANT_CNT_EN
        cnt_clr = 1'b0;
`endif
        a_req = 1'b1;

        // Reset state: wait mirrors req, no access, no response, clken low
        @(negedge clk);
        check("rst_a_wait", a_wait, 1);
        check("rst_b_wait", b_wait, 0);
        check("rst_cs", mem_cs, 0);
        check("rst_write", mem_write, 0);
        check("rst_clken", mem_clken, 0);
        check("rst_a_rvalid", a_rvalid, 0);
        check("rst_b_rvalid", b_rvalid, 0);
        a_req = 1'b0;
        reset = 1'b0;
        next_cycle();
        @(negedge clk);
        check("post_rst_clken", mem_clken, 1);
        check("post_rst_cs", mem_cs, 0);
        next_cycle();

        // Tie from reset: A first, B next, then B keeps ownership on a new tie
        a_req = 1'b1; a_write = 1'b0; a_addr = 13'h020;
        b_req = 1'b1; b_write = 1'b0; b_addr = 13'h021;
        @(negedge clk);
        check("t2_c0_a_wait", a_wait, 0);
        check("t2_c0_b_wait", b_wait, 1);
        check("t2_c0_addr", mem_addr, 13'h020);
        next_cycle();
        a_req = 1'b0;
        @(negedge clk);
        check("t2_c1_b_wait", b_wait, 0);
        check("t2_c1_addr", mem_addr, 13'h021);
        check("t2_c1_a_rvalid", a_rvalid, 1);
        check("t2_c1_a_rdata", a_rdata, 32'h11111111);
        next_cycle();
        a_req = 1'b1; a_addr = 13'h022; b_addr = 13'h023;
        @(negedge clk);
        check("t2_c2_b_wait", b_wait, 0);
        check("t2_c2_a_wait", a_wait, 1);
        check("t2_c2_addr", mem_addr, 13'h023);
        check("t2_c2_b_rvalid", b_rvalid, 1);
        check("t2_c2_b_rdata", b_rdata, 32'h22222222);
        check("t2_c2_a_rvalid", a_rvalid, 0);
        next_cycle();
        b_req = 1'b0;
        @(negedge clk);
        check("t2_c3_a_wait", a_wait, 0);
        check("t2_c3_addr", mem_addr, 13'h022);
        check("t2_c3_b_rvalid", b_rvalid, 1);
        check("t2_c3_b_rdata", b_rdata, 32'h44444444);
        next_cycle();
        a_req = 1'b0;
        @(negedge clk);
        check("t2_c4_a_rvalid", a_rvalid, 1);
        check("t2_c4_a_rdata", a_rdata, 32'h33333333);
        check("t2_c4_cs", mem_cs, 0);
        next_cycle();

        // A-only read with one-cycle latency
        acc(1'b0, 1'b0, 13'h0010, '0, '1, "t1_rd");
        @(negedge clk);
        check("t1_a_rvalid", a_rvalid, 1);
        check("t1_a_rdata", a_rdata, 32'hDEADBEEF);
        check("t1_b_rvalid", b_rvalid, 0);
        next_cycle();

        // Starvation bound: A streams 10 reads, B requests from cycle 2
        a_cnt = 0; b_gcyc = -1; a_lastcyc = -1; b_chk = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (a_cnt >= 10 && b_gcyc >= 0) break;
            if (cyc == 2) begin
                b_req = 1'b1; b_write = 1'b0; b_addr = 13'h040;
            end
            a_req   = (a_cnt < 10);
            a_write = 1'b0;
            a_addr  = 13'(13'h030 + a_cnt);
            @(negedge clk);
            if (b_chk) begin
                check("t3_b_rvalid", b_rvalid, 1);
                check("t3_b_rdata", b_rdata, 32'h55555555);
                b_chk = 1'b0;
            end
            ga = a_req && !a_wait;
            gb = b_req && !b_wait;
            if (ga && gb) check("t3_one_grant", 2, 1);
            next_cycle();
            if (ga) begin
                a_cnt++;
                a_lastcyc = cyc;
            end
            if (gb) begin
                b_req  = 1'b0;
                b_gcyc = cyc;
                b_chk  = 1'b1;
            end
        end
        a_req = 1'b0;
        check("t3_b_grant_cycle", b_gcyc, 5);
        check("t3_a_last_cycle", a_lastcyc, 10);
        check("t3_a_count", a_cnt, 10);

        // Byte-enabled write from B, then read-back from A the next cycle
        acc(1'b1, 1'b1, 13'h1FFF, 32'hAABBCCDD, 4'b0101, "t4_wr");
        acc(1'b0, 1'b0, 13'h1FFF, '0, '1, "t4_rd");
        @(negedge clk);
        check("t4_a_rvalid", a_rvalid, 1);
        check("t4_a_rdata", a_rdata, 32'h00BB00DD);
        check("t4_b_rvalid", b_rvalid, 0);
        next_cycle();

        // Reset the cycle after a read is accepted: response is dropped
        a_req = 1'b1; a_write = 1'b0; a_addr = 13'h0010;
        @(negedge clk);
        check("t5_accept", a_wait, 0);
        next_cycle();
        a_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("t5_rvalid_in_rst", a_rvalid, 0);
        check("t5_clken_in_rst", mem_clken, 0);
        reset = 1'b0;
        next_cycle();
        @(negedge clk);
        check("t5_rvalid_after", a_rvalid, 0);
        next_cycle();
        // Back in IDLE with last=B, so a tie goes to A
        a_req = 1'b1; a_write = 1'b0; a_addr = 13'h020;
        b_req = 1'b1; b_write = 1'b0; b_addr = 13'h021;
        @(negedge clk);
        check("t5_tie_a_wait", a_wait, 0);
        check("t5_tie_b_wait", b_wait, 1);
        next_cycle();
        a_req = 1'b0;
        @(negedge clk);
        check("t5_b_wait", b_wait, 0);
        next_cycle();
        b_req = 1'b0;

`ifdef MEM_ARB_GRANT_CNT_EN
        // One A and one B access since the last reset; add 4 A and 2 B more
        for (int i = 0; i < 4; i++) acc(1'b0, 1'b0, 13'h020, '0, '1, "t6_a");
        for (int i = 0; i < 2; i++) acc(1'b1, 1'b0, 13'h021, '0, '1, "t6_b");
        @(negedge clk);
        check("t6_a_cnt", a_grant_cnt, 5);
        check("t6_b_cnt", b_grant_cnt, 3);
        next_cycle();
        cnt_clr = 1'b1;
        next_cycle();
        cnt_clr = 1'b0;
        @(negedge clk);
        check("t6_a_cnt_clr", a_grant_cnt, 0);
        check("t6_b_cnt_clr", b_grant_cnt, 0);
`endif

        next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
